// File: rtl/move_input_conditioner_pkg.sv
// Shared types and default timing for the push-button move conditioner.
//   dir_t        : move direction, also the button index and the arbitration
//                  priority (lower value wins)
//   rpt_state_t  : hold-to-repeat state
//   DEF_*        : default timing at 50 MHz
//   multi_hot()  : true when more than one bit of a button vector is set
package move_pkg;

  typedef enum logic [1:0] {
    DIR_UP    = 2'd0,
    DIR_DOWN  = 2'd1,
    DIR_LEFT  = 2'd2,
    DIR_RIGHT = 2'd3
  } dir_t;

  typedef enum logic [1:0] {
    RPT_IDLE   = 2'd0,
    RPT_DELAY  = 2'd1,
    RPT_REPEAT = 2'd2
  } rpt_state_t;

  localparam int unsigned NUM_BTN                 = 4;
  localparam int unsigned DEF_SYNC_STAGES         = 2;
  localparam int unsigned DEF_DEBOUNCE_CYCLES     = 500_000;
  localparam int unsigned DEF_REPEAT_DELAY_CYCLES = 25_000_000;
  localparam int unsigned DEF_REPEAT_RATE_CYCLES  = 10_000_000;

  function automatic logic multi_hot(input logic [NUM_BTN-1:0] v);
    return (v & (v - 1'b1)) != '0;
  endfunction

endpackage

// File: rtl/move_input_conditioner_btn_debounce.sv
// One button: synchroniser chain, stability counter and debounced level.
//   clk, rst        : clock, asynchronous active-low reset
//   btn_n_i         : raw active-low button, asynchronous to clk
//   stable_next_o   : debounced level as it will be after this clock edge
//   press_o         : debounced level falls (1->0) on this clock edge
// Both outputs are combinational views of this edge's update so the parent can
// register its pulse in the same edge that the debounced level changes.
module btn_debounce #(
  parameter int unsigned SYNC_STAGES     = 2,
  parameter int unsigned DEBOUNCE_CYCLES = 500_000
) (
  input  logic clk,
  input  logic rst,
  input  logic btn_n_i,
  output logic stable_next_o,
  output logic press_o
);

  localparam int unsigned CW = $clog2(DEBOUNCE_CYCLES + 1);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   synced;
  logic                   stable_q, stable_d;
  logic [CW-1:0]          cnt_q, cnt_d;

  assign synced = sync_q[SYNC_STAGES-1];

  always_comb begin
    stable_d = stable_q;
    cnt_d    = cnt_q;
    if (synced == stable_q) begin
      cnt_d = '0;
    end else if (cnt_q == CW'(DEBOUNCE_CYCLES - 1)) begin
      stable_d = synced;
      cnt_d    = '0;
    end else begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync_q   <= '1;
      stable_q <= 1'b1;
      cnt_q    <= '0;
    end else begin
      sync_q   <= {sync_q[SYNC_STAGES-2:0], btn_n_i};
      stable_q <= stable_d;
      cnt_q    <= cnt_d;
    end
  end

  assign stable_next_o = stable_d;
  assign press_o       = stable_q & ~stable_d;

endmodule

// File: rtl/move_input_conditioner.sv
// Push-button move conditioner for the ship-placement cursor.
//   clk, rst      : clock, asynchronous active-low reset
//   enable        : 1 allows move pulses, 0 suppresses them and clears pending/repeat
//   btn_*_n       : raw active-low buttons
//   move_*        : registered active-low one-cycle move strobes, at most one low
//   any_pressed   : registered, high while any debounced button is held
// Simultaneous presses are serialised UP > DOWN > LEFT > RIGHT through a pending
// set; a sole held button auto-repeats after a delay, then at a fixed rate.
module move_input_conditioner
  import move_pkg::*;
#(
  parameter int unsigned SYNC_STAGES         = DEF_SYNC_STAGES,
  parameter int unsigned DEBOUNCE_CYCLES     = DEF_DEBOUNCE_CYCLES,
  parameter int unsigned REPEAT_DELAY_CYCLES = DEF_REPEAT_DELAY_CYCLES,
  parameter int unsigned REPEAT_RATE_CYCLES  = DEF_REPEAT_RATE_CYCLES
) (
  input  logic clk,
  input  logic rst,
  input  logic enable,
  input  logic btn_up_n,
  input  logic btn_down_n,
  input  logic btn_left_n,
  input  logic btn_right_n,
  output logic move_up,
  output logic move_down,
  output logic move_left,
  output logic move_right,
  output logic any_pressed
);

  localparam int unsigned RPT_MAX = (REPEAT_DELAY_CYCLES > REPEAT_RATE_CYCLES) ?
                                    REPEAT_DELAY_CYCLES : REPEAT_RATE_CYCLES;
  localparam int unsigned RCW     = $clog2(RPT_MAX + 1);

  logic [NUM_BTN-1:0] raw_n;
  logic [NUM_BTN-1:0] stable_next;
  logic [NUM_BTN-1:0] press;
  logic [NUM_BTN-1:0] held;
  logic [NUM_BTN-1:0] req;
  logic [NUM_BTN-1:0] win_oh;
  dir_t               emit_dir;

  rpt_state_t         state_q, state_d;
  dir_t               dir_q, dir_d;
  logic [RCW-1:0]     rcnt_q, rcnt_d;
  logic [RCW-1:0]     rpt_limit;
  logic [NUM_BTN-1:0] pend_q, pend_d;
  logic [NUM_BTN-1:0] move_q, move_d;
  logic               any_q;

  // Bit index equals dir_t value.
  assign raw_n = {btn_right_n, btn_left_n, btn_down_n, btn_up_n};

  for (genvar g = 0; g < NUM_BTN; g++) begin : g_btn
    btn_debounce #(
      .SYNC_STAGES    (SYNC_STAGES),
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_db (
      .clk          (clk),
      .rst          (rst),
      .btn_n_i      (raw_n[g]),
      .stable_next_o(stable_next[g]),
      .press_o      (press[g])
    );
  end

  assign held = ~stable_next;
  assign req  = pend_q | press;

  always_comb begin
    if (req[DIR_UP])        emit_dir = DIR_UP;
    else if (req[DIR_DOWN]) emit_dir = DIR_DOWN;
    else if (req[DIR_LEFT]) emit_dir = DIR_LEFT;
    else                    emit_dir = DIR_RIGHT;
  end

  assign win_oh    = NUM_BTN'(1) << emit_dir;
  assign rpt_limit = (state_q == RPT_DELAY) ? RCW'(REPEAT_DELAY_CYCLES - 1)
                                            : RCW'(REPEAT_RATE_CYCLES - 1);

  // Hold/repeat decisions use the debounced levels after this edge so that a
  // press and its own pulse are seen together. A due repeat that collides with
  // an edge pulse is dropped but its period still restarts.
  always_comb begin
    state_d = state_q;
    dir_d   = dir_q;
    rcnt_d  = rcnt_q;
    pend_d  = pend_q;
    move_d  = '1;
    if (!enable) begin
      state_d = RPT_IDLE;
      rcnt_d  = '0;
      pend_d  = '0;
    end else begin
      if (req != '0) begin
        move_d[emit_dir] = 1'b0;
        pend_d           = req & ~win_oh;
      end
      if (req != '0 && held == win_oh) begin
        state_d = RPT_DELAY;
        dir_d   = emit_dir;
        rcnt_d  = '0;
      end else if (state_q != RPT_IDLE) begin
        if (!held[dir_q] || multi_hot(held)) begin
          state_d = RPT_IDLE;
          rcnt_d  = '0;
        end else if (rcnt_q == rpt_limit) begin
          if (req == '0) move_d[dir_q] = 1'b0;
          state_d = RPT_REPEAT;
          rcnt_d  = '0;
        end else begin
          rcnt_d = rcnt_q + 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= RPT_IDLE;
      dir_q   <= DIR_UP;
      rcnt_q  <= '0;
      pend_q  <= '0;
      move_q  <= '1;
      any_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      dir_q   <= dir_d;
      rcnt_q  <= rcnt_d;
      pend_q  <= pend_d;
      move_q  <= move_d;
      any_q   <= ~&stable_next;
    end
  end

  assign move_up     = move_q[DIR_UP];
  assign move_down   = move_q[DIR_DOWN];
  assign move_left   = move_q[DIR_LEFT];
  assign move_right  = move_q[DIR_RIGHT];
  assign any_pressed = any_q;

endmodule

// File: tb/tb_move_input_conditioner.sv
module tb_move_input_conditioner;

  localparam int SS = 2;
  localparam int DB = 4;
  localparam int RD = 20;
  localparam int RR = 8;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       enable = 1'b0;
  logic [3:0] raw_n = 4'hF;  // 0 up, 1 down, 2 left, 3 right
  logic       move_up, move_down, move_left, move_right, any_pressed;

  always #5 clk = ~clk;

  move_input_conditioner #(
    .SYNC_STAGES        (SS),
    .DEBOUNCE_CYCLES    (DB),
    .REPEAT_DELAY_CYCLES(RD),
    .REPEAT_RATE_CYCLES (RR)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .enable     (enable),
    .btn_up_n   (raw_n[0]),
    .btn_down_n (raw_n[1]),
    .btn_left_n (raw_n[2]),
    .btn_right_n(raw_n[3]),
    .move_up    (move_up),
    .move_down  (move_down),
    .move_left  (move_left),
    .move_right (move_right),
    .any_pressed(any_pressed)
  );

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int seen [4] = '{0, 0, 0, 0};
  int base [4] = '{0, 0, 0, 0};

  // Scoreboard of expected pulses: edge number and direction.
  int exp_cyc_q [$];
  int exp_dir_q [$];

  // Reference model: raw history per button, debounced level, pending set,
  // and repeat as "next due edge" timestamps.
  int  hist [4][SS+DB];
  bit  m_stable [4];
  bit  m_pend [4];
  bit  m_anyp;
  bit  m_active;
  int  m_dir;
  int  m_next_fire;

  task automatic push_exp(input int c, input int d);
    exp_cyc_q.push_back(c);
    exp_dir_q.push_back(d);
  endtask

  task automatic model_reset();
    for (int b = 0; b < 4; b++) begin
      for (int j = 0; j < SS + DB; j++) hist[b][j] = 1;
      m_stable[b] = 1'b1;
      m_pend[b]   = 1'b0;
    end
    m_anyp   = 1'b0;
    m_active = 1'b0;
    exp_cyc_q.delete();
    exp_dir_q.delete();
  endtask

  task automatic model_step();
    bit press [4];
    bit held  [4];
    int nheld;
    int win;
    bit all_opp;
    nheld = 0;
    for (int b = 0; b < 4; b++) begin
      for (int j = SS + DB - 1; j > 0; j--) hist[b][j] = hist[b][j-1];
      hist[b][0] = int'(raw_n[b]);
      // Level accepted once the synchronised value (raw delayed SS edges)
      // has disagreed with the debounced level for DB consecutive edges.
      all_opp = 1'b1;
      for (int j = SS; j < SS + DB; j++)
        if (hist[b][j] == int'(m_stable[b])) all_opp = 1'b0;
      press[b] = 1'b0;
      if (all_opp) begin
        press[b]    = m_stable[b];
        m_stable[b] = ~m_stable[b];
      end
      held[b] = ~m_stable[b];
      if (held[b]) nheld++;
    end
    m_anyp = (nheld != 0);
    if (!enable) begin
      for (int b = 0; b < 4; b++) m_pend[b] = 1'b0;
      m_active = 1'b0;
    end else begin
      win = -1;
      for (int b = 0; b < 4; b++)
        if ((m_pend[b] || press[b]) && win < 0) win = b;
      for (int b = 0; b < 4; b++)
        m_pend[b] = (m_pend[b] || press[b]) && (b != win);
      if (win >= 0) push_exp(cyc, win);
      if (win >= 0 && nheld == 1 && held[win]) begin
        m_active    = 1'b1;
        m_dir       = win;
        m_next_fire = cyc + RD;
      end else if (m_active) begin
        if (!held[m_dir] || nheld > 1) begin
          m_active = 1'b0;
        end else if (cyc == m_next_fire) begin
          if (win < 0) push_exp(cyc, m_dir);
          m_next_fire = cyc + RR;
        end
      end
    end
  endtask

  always @(posedge clk) begin
    cyc++;
    if (!rst) model_reset();
    else      model_step();
  end

  // Monitor: pops the scoreboard whenever a strobe is seen.
  always @(negedge clk) begin
    logic [3:0] mv;
    int d, ec, ed;
    mv = {move_right, move_left, move_down, move_up};
    if (rst) begin
      checks++;
      if (any_pressed !== m_anyp) begin
        failures++;
        $display("FAIL any_pressed cyc=%0d got=%0b exp=%0b", cyc, any_pressed, m_anyp);
      end
      if (mv !== 4'hF) begin
        checks++;
        if ($countones(~mv) != 1) begin
          failures++;
          $display("FAIL one_low cyc=%0d got=%b exp=one bit low", cyc, mv);
        end
        d = 0;
        for (int b = 0; b < 4; b++) if (!mv[b]) begin d = b; seen[b]++; end
        if (exp_cyc_q.size() == 0) begin
          failures++;
          $display("FAIL unexpected_pulse cyc=%0d got dir=%0d exp=none", cyc, d);
        end else begin
          ec = exp_cyc_q.pop_front();
          ed = exp_dir_q.pop_front();
          checks++;
          if (ec != cyc || ed != d) begin
            failures++;
            $display("FAIL pulse got cyc=%0d dir=%0d exp cyc=%0d dir=%0d", cyc, d, ec, ed);
          end
        end
      end
      while (exp_cyc_q.size() > 0 && exp_cyc_q[0] < cyc) begin
        checks++;
        failures++;
        $display("FAIL missed_pulse cyc=%0d exp cyc=%0d dir=%0d got=none",
                 cyc, exp_cyc_q[0], exp_dir_q[0]);
        void'(exp_cyc_q.pop_front());
        void'(exp_dir_q.pop_front());
      end
    end
  end

  task automatic cycles(input int n);
    repeat (n) @(negedge clk);
    #1;
  endtask

  task automatic snap();
    for (int b = 0; b < 4; b++) base[b] = seen[b];
  endtask

  task automatic expect_count(input string name, input int b, input int exp_n);
    checks++;
    if (seen[b] - base[b] != exp_n) begin
      failures++;
      $display("FAIL %s got=%0d exp=%0d", name, seen[b] - base[b], exp_n);
    end
  endtask

  initial begin
    #2;
    rst   = 1'b0;
    raw_n = 4'h0;
    cycles(5);
    checks++;
    if ({move_right, move_left, move_down, move_up} !== 4'hF || any_pressed !== 1'b0) begin
      failures++;
      $display("FAIL reset_state got moves=%b any=%b exp moves=1111 any=0",
               {move_right, move_left, move_down, move_up}, any_pressed);
    end

    // Release reset with all buttons held: one pulse each, in priority order.
    snap();
    rst    = 1'b1;
    enable = 1'b1;
    cycles(14);
    expect_count("reset_up", 0, 1);
    expect_count("reset_down", 1, 1);
    expect_count("reset_left", 2, 1);
    expect_count("reset_right", 3, 1);
    raw_n = 4'hF;
    cycles(12);

    // Bounce on left.
    snap();
    for (int i = 0; i < 10; i++) begin
      raw_n[2] = i[0];
      cycles(2);
    end
    raw_n[2] = 1'b0;
    cycles(12);
    expect_count("bounce_left", 2, 1);
    raw_n[2] = 1'b1;
    cycles(12);

    // Simultaneous up + right.
    snap();
    raw_n[0] = 1'b0;
    raw_n[3] = 1'b0;
    cycles(14);
    expect_count("simul_up", 0, 1);
    expect_count("simul_right", 3, 1);
    raw_n = 4'hF;
    cycles(12);

    // Hold down 60 cycles: press + 5 repeats.
    snap();
    raw_n[1] = 1'b0;
    cycles(60);
    raw_n[1] = 1'b1;
    cycles(30);
    expect_count("repeat_down", 1, 6);

    // Second button during repeat stops repeating.
    snap();
    raw_n[1] = 1'b0;
    cycles(40);
    raw_n[2] = 1'b0;
    cycles(30);
    expect_count("second_left", 2, 1);
    expect_count("second_down", 1, 4);
    raw_n = 4'hF;
    cycles(12);

    // enable low while pressing, raised while held, then a fresh press.
    snap();
    enable   = 1'b0;
    raw_n[0] = 1'b0;
    cycles(12);
    enable = 1'b1;
    cycles(30);
    expect_count("enable_held", 0, 0);
    raw_n[0] = 1'b1;
    cycles(10);
    raw_n[0] = 1'b0;
    cycles(10);
    raw_n[0] = 1'b1;
    cycles(10);
    expect_count("enable_repress", 0, 1);

    // Reset mid-press gives one fresh pulse.
    snap();
    raw_n[3] = 1'b0;
    cycles(10);
    rst = 1'b0;
    cycles(3);
    rst = 1'b1;
    cycles(10);
    expect_count("reset_midpress", 3, 2);
    raw_n[3] = 1'b1;
    cycles(12);

    // Randomised phase.
    for (int s = 0; s < 160; s++) begin
      for (int b = 0; b < 4; b++)
        if ($urandom_range(0, 3) == 0) raw_n[b] = ~raw_n[b];
      enable = ($urandom_range(0, 15) != 0);
      if ($urandom_range(0, 99) == 0) begin
        rst = 1'b0;
        cycles(2);
        rst = 1'b1;
      end
      cycles((($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 4))
                                          : int'($urandom_range(5, 40))));
    end

    raw_n  = 4'hF;
    enable = 1'b1;
    cycles(40);
    checks++;
    if (exp_cyc_q.size() != 0) begin
      failures++;
      $display("FAIL scoreboard_empty got=%0d exp=0", exp_cyc_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
